// File: rtl/shift_reg_seq.sv
// WIDTH-bit universal shift/rotate register with parallel load, serial I/O and
// a start/busy/done sequencer that repeats one shift operation N times.
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             done_q, done_d;
    logic             isShift;

    function automatic logic [WIDTH-1:0] stepOp(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            3'b000: res = cur;
            3'b001: res = ld;
            3'b010: res = {cur[WIDTH-2:0], sr};
            3'b011: res = {sl, cur[WIDTH-1:1]};
            3'b100: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101: res = {cur[0], cur[WIDTH-1:1]};
            3'b110: res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'b111: res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Only the shift/rotate family (010..110) can be sequenced.
    assign isShift = (mode >= 3'b010) && (mode <= 3'b110);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && isShift) begin
                    if (amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        cnt_d   = amount;
                        state_d = RUN;
                    end
                end else if (start || en) begin
                    reg_d = stepOp(mode, reg_q, d, sin_l, sin_r);
                end
            end
            RUN: begin
                reg_d = stepOp(mode_q, reg_q, d, sin_l, sin_r);
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            reg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            done_q  <= done_d;
        end
    end

    assign q      = reg_q;
    assign sout_l = reg_q[WIDTH-1];
    assign sout_r = reg_q[0];
    assign busy   = (state_q == RUN);
    assign done   = done_q;

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit universal shift/rotate register with parallel load, serial I/O and a multi-cycle "shift-by-N" sequencer.
- Used as the datapath register in lab shifter/ALU exercises.
- Single-step operations complete in one clock.
- A start pulse runs N steps autonomously with busy/done status.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the step-count input; 2**AMT_W-1 must be >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at rst=0).
- en  input  1  single-step enable; honoured only when idle.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial in at MSB (used by shr).
- sin_r  input  1  serial in at LSB (used by shl).
- start  input  1  one-cycle request to run the latched mode for `amount` steps.
- amount  input  AMT_W  step count for a sequenced run.
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1].
- sout_r  output  1  equals q[0].
- busy  output  1  sequencer running.
- done  output  1  one-cycle pulse when a sequenced run completes.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-low. While rst=0: q=0, busy=0, done=0, sequencer in IDLE, latched mode and counter cleared. Reset mid-run aborts the run immediately with no done pulse.
- Mode encoding (one step):
  - 000: hold.
  - 001: load d.
  - 010: shl, q <= {q[W-2:0], sin_r}.
  - 011: shr, q <= {sin_l, q[W-1:1]}.
  - 100: rotl.
  - 101: rotr.
  - 110: ashr, MSB replicated.
  - 111: clear to 0.
- All outputs are registered, except sout_l and sout_r, which are taps of q.
- Sequencer states are IDLE and RUN. done is a registered flag.
- IDLE, start=0, en=1: one step of `mode` at the edge. en=0 holds q.
- IDLE, start=1, mode in {010..110}, amount>0: at this edge, latch mode and amount, go to RUN, busy=1, q unchanged.
- IDLE, start=1, amount=0 (shift mode): no run; done=1 for the next cycle, busy stays 0, q unchanged.
- IDLE, start=1, mode in {000,001,111}: start is ignored and the cycle behaves as en=1 single-step. No busy, no done.
- start and en together: start has priority.
- RUN: each edge performs one step of the latched mode and decrements the counter.
  - sin_l/sin_r are sampled live at every step.
  - en, start, mode, d and amount are ignored while busy.
- RUN, completion: the edge performing step N goes to IDLE, busy=0, done=1. q shows the final value in the same cycle done is high.
- done deasserts at the following edge unless a new amount=0 start re-asserts it.
- Latency: N+1 rising edges from the start-sampling edge to done.
- amount>WIDTH is legal: shl/shr fill fully with the serial inputs, rotates wrap modulo WIDTH, ashr saturates to all-sign.
- The first start is accepted at the same edge that done is asserted? No: start is sampled only in IDLE, so a new start can be accepted in the cycle done is high.

Test Plan:
1. Reset: drive rst=0 mid-run with q=8'hA5 -> q=0, busy=0, done=0 immediately (no clk edge needed). Release rst -> IDLE.
2. Single steps: load d=8'hB4, then mode=100 en=1 -> q=8'h69. mode=110 -> q=8'h34. mode=011, sin_l=1 -> q=8'h9A. mode=111 -> q=0.
3. Sequenced rotate: q=8'h81, start with mode=101, amount=3.
   - busy high for 3 cycles.
   - done at the 4th edge after start with q=8'h30.
   - en/d toggled during busy have no effect.
4. Edge amounts:
   - amount=0 start -> done one cycle, busy never 1, q unchanged.
   - shl amount=10, sin_r=1, from q=8'h00 -> q=8'hFF, done after 11 edges.
   - rotl amount=8 -> q returns to its start value.
5. Priority/ignores:
   - start+en with mode=010 -> sequenced run taken.
   - start with mode=001 -> single load, no busy/done.
   - Back-to-back start in the done cycle -> new run accepted.
6. Serial tap: shr run of 8 with sin_l fed from sout_r -> acts as rotr, q unchanged after 8 steps. sout_l/sout_r track q[7]/q[0] every cycle.
